// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller and the alignment unit.
package dmem_ctrl_pkg;

    // Access codes, shared with the load/store alignment unit
    localparam logic [3:0] ACC_LB  = 4'd0;
    localparam logic [3:0] ACC_LH  = 4'd1;
    localparam logic [3:0] ACC_LW  = 4'd2;
    localparam logic [3:0] ACC_LBU = 4'd3;
    localparam logic [3:0] ACC_LHU = 4'd4;
    localparam logic [3:0] ACC_SB  = 4'd5;
    localparam logic [3:0] ACC_SH  = 4'd6;
    localparam logic [3:0] ACC_SW  = 4'd7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_DATA,
        ST_WR,
        ST_RESP
    } state_t;

    function automatic logic is_store(input logic [3:0] access);
        return (access == ACC_SB) || (access == ACC_SH) || (access == ACC_SW);
    endfunction

endpackage

// File: rtl/dmem_align_chk.sv
// Alignment / legality check of an access, evaluated at request acceptance.
import dmem_ctrl_pkg::*;

module dmem_align_chk (
    input  logic [1:0] addr_lo,
    input  logic [3:0] access,
    output logic       err
);

    // Halfwords need an even address, words a 4-byte boundary, codes above SW are illegal
    always_comb begin
        err = 1'b0;
        case (access)
            ACC_LB, ACC_LBU, ACC_SB: err = 1'b0;
            ACC_LH, ACC_LHU, ACC_SH: err = addr_lo[0];
            ACC_LW, ACC_SW:          err = |addr_lo;
            default:                 err = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access sequencer: loads, read-modify-write for SB/SH, direct SW.
import dmem_ctrl_pkg::*;

module dmem_ctrl #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic [3:0]        req_access,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    output logic [31:0]       slu_addr,
    output logic [3:0]        slu_access,
    output logic [31:0]       slu_rd_in,
    output logic [31:0]       slu_wd_in,
    input  logic [31:0]       slu_rd_out,
    input  logic [31:0]       slu_wd_out
);

    state_t      state, state_nx;
    logic [31:0] addr_q;
    logic [3:0]  access_q;
    logic [31:0] wdata_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;
    logic        chk_err;
    logic        accept;

    dmem_align_chk u_chk (
        .addr_lo (req_addr[1:0]),
        .access  (req_access),
        .err     (chk_err)
    );

    assign accept = req_valid && (state == ST_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // Next-state: errors skip memory, SW skips the read, SB/SH merge before writing
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (chk_err)                   state_nx = ST_RESP;
                    else if (req_access == ACC_SW) state_nx = ST_WR;
                    else                           state_nx = ST_RD;
                end
            end
            ST_RD:   state_nx = ST_DATA;
            ST_DATA: state_nx = is_store(access_q) ? ST_WR : ST_RESP;
            ST_WR:   state_nx = ST_RESP;
            ST_RESP: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Request latch, write-word and response registers; response regs change only on RESP entry
    always_ff @(posedge clk) begin
        if (!rstn) begin
            addr_q       <= '0;
            access_q     <= '0;
            wdata_q      <= '0;
            mem_wdata_q  <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q   <= req_addr;
                        access_q <= req_access;
                        wdata_q  <= req_wdata;
                        if (chk_err) begin
                            resp_rdata_q <= '0;
                            resp_err_q   <= 1'b1;
                        end else if (req_access == ACC_SW) begin
                            mem_wdata_q <= req_wdata;
                        end
                    end
                end
                ST_DATA: begin
                    if (is_store(access_q)) begin
                        mem_wdata_q <= slu_wd_out;
                    end else begin
                        resp_rdata_q <= slu_rd_out;
                        resp_err_q   <= 1'b0;
                    end
                end
                ST_WR: begin
                    resp_rdata_q <= '0;
                    resp_err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state == ST_IDLE);
    assign stall      = (state != ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign mem_re     = (state == ST_RD);
    assign mem_we     = (state == ST_WR);
    assign mem_addr   = addr_q[ADDR_W+1:2];
    assign mem_wdata  = mem_wdata_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign slu_addr   = addr_q;
    assign slu_access = access_q;
    assign slu_rd_in  = (state == ST_DATA) ? mem_rdata : 32'd0;
    assign slu_wd_in  = wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: memory + alignment-unit environment, reference model.
module tb_dmem_ctrl;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rstn;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic [3:0]        req_access;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              stall;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [31:0]       mem_rdata;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       slu_addr;
    logic [3:0]        slu_access;
    logic [31:0]       slu_rd_in;
    logic [31:0]       slu_wd_in;
    logic [31:0]       slu_rd_out;
    logic [31:0]       slu_wd_out;

    dmem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_access(req_access), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .stall(stall), .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_wdata(mem_wdata),
        .slu_addr(slu_addr), .slu_access(slu_access), .slu_rd_in(slu_rd_in),
        .slu_wd_in(slu_wd_in), .slu_rd_out(slu_rd_out), .slu_wd_out(slu_wd_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Environment: synchronous memory with one-cycle read latency, plus strobe monitors
    logic [31:0] mem     [0:(1<<ADDR_W)-1];
    logic [31:0] ref_mem [0:(1<<ADDR_W)-1];
    int          re_cnt = 0;
    int          we_cnt = 0;
    int          both_cnt = 0;
    logic [31:0] last_we_data = '0;

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            we_cnt        <= we_cnt + 1;
            last_we_data  <= mem_wdata;
        end
        if (mem_re) begin
            mem_rdata <= mem[mem_addr];
            re_cnt    <= re_cnt + 1;
        end
        if (mem_re && mem_we) both_cnt <= both_cnt + 1;
    end

    // Environment: behavioural load/store alignment unit
    logic [7:0]  slu_b;
    logic [15:0] slu_h;
    always_comb begin
        slu_b      = slu_rd_in[8*slu_addr[1:0] +: 8];
        slu_h      = slu_addr[1] ? slu_rd_in[31:16] : slu_rd_in[15:0];
        slu_rd_out = slu_rd_in;
        slu_wd_out = slu_rd_in;
        case (slu_access)
            4'd0: slu_rd_out = {{24{slu_b[7]}}, slu_b};
            4'd1: slu_rd_out = {{16{slu_h[15]}}, slu_h};
            4'd3: slu_rd_out = {24'd0, slu_b};
            4'd4: slu_rd_out = {16'd0, slu_h};
            4'd5: slu_wd_out[8*slu_addr[1:0] +: 8] = slu_wd_in[7:0];
            4'd6: slu_wd_out[16*slu_addr[1] +: 16] = slu_wd_in[15:0];
            4'd7: slu_wd_out = slu_wd_in;
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Reference model: result, error, latency and strobe counts of one access
    task automatic ref_access(input logic [31:0] a, input logic [3:0] acc, input logic [31:0] wd,
                              output logic [31:0] rd, output logic err,
                              output int lat, output int nre, output int nwe);
        int unsigned idx, sh;
        logic [31:0] w, mask;
        idx = (a / 4) % (1 << ADDR_W);
        sh  = (a % 4) * 8;
        w   = ref_mem[idx];
        rd  = 0; err = 0; nre = 0; nwe = 0; lat = 0;
        if (acc > 7) err = 1;
        else if ((acc == 1 || acc == 4 || acc == 6) && (a % 2) != 0) err = 1;
        else if ((acc == 2 || acc == 7) && (a % 4) != 0) err = 1;
        if (err) begin
            lat = 1;
        end else if (acc == 7) begin
            ref_mem[idx] = wd; lat = 2; nwe = 1;
        end else if (acc == 5 || acc == 6) begin
            mask = (acc == 5) ? 32'hFF : 32'hFFFF;
            ref_mem[idx] = (w & ~(mask << sh)) | ((wd & mask) << sh);
            lat = 4; nre = 1; nwe = 1;
        end else begin
            lat = 3; nre = 1;
            case (acc)
                0: begin rd = (w >> sh) & 32'hFF;   if (rd >= 128)   rd = rd - 256;   end
                1: begin rd = (w >> sh) & 32'hFFFF; if (rd >= 32768) rd = rd - 65536; end
                3: rd = (w >> sh) & 32'hFF;
                4: rd = (w >> sh) & 32'hFFFF;
                default: rd = w;
            endcase
        end
    endtask

    logic [31:0] last_rd;

    // One full transaction: drive, time the response, compare against the model
    task automatic do_req(input logic [31:0] a, input logic [3:0] acc, input logic [31:0] wd);
        logic [31:0] erd;
        logic        eerr;
        int          elat, enre, enwe, re0, we0, lat;
        bit          got;
        ref_access(a, acc, wd, erd, eerr, elat, enre, enwe);
        @(negedge clk);
        check("ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_addr = a; req_access = acc; req_wdata = wd;
        re0 = re_cnt; we0 = we_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom; req_access = 4'($urandom); req_wdata = $urandom;
        check("we_first", {31'd0, mem_we}, {31'd0, elat == 2});
        lat = 1; got = 0;
        while (!got && lat <= 8) begin
            if (resp_valid === 1'b1) got = 1;
            else begin @(posedge clk); #1; lat++; end
        end
        check("latency", 32'(lat), 32'(elat));
        check("rdata", resp_rdata, erd);
        check("err", {31'd0, resp_err}, {31'd0, eerr});
        check("re_count", 32'(re_cnt - re0), 32'(enre));
        check("we_count", 32'(we_cnt - we0), 32'(enwe));
        last_rd = resp_rdata;
        @(posedge clk); #1;
        check("resp_pulse", {31'd0, resp_valid}, 32'd0);
        check("rdata_hold", resp_rdata, erd);
    endtask

    initial begin
        logic [31:0] v, a;
        logic [3:0]  acc;
        int          we0;
        rstn = 1'b0; req_valid = 1'b0; req_addr = '0; req_access = '0; req_wdata = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            v = $urandom; mem[i] = v; ref_mem[i] = v;
        end
        mem[16] = 32'h8899AABB; ref_mem[16] = 32'h8899AABB;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_strobes", {30'd0, mem_re, mem_we}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        @(negedge clk); rstn = 1'b1;

        // Directed loads and stores around word 0x40
        do_req(32'h41, 4'd0, 32'h0);         check("lb_value", last_rd, 32'hFFFFFFAA);
        do_req(32'h42, 4'd4, 32'h0);         check("lhu_value", last_rd, 32'h00008899);
        do_req(32'h40, 4'd2, 32'h0);         check("lw_value", last_rd, 32'h8899AABB);
        do_req(32'h43, 4'd5, 32'h12);        check("sb_merge", last_we_data, 32'h1299AABB);
        do_req(32'h40, 4'd2, 32'h0);         check("lw_after_sb", last_rd, 32'h1299AABB);
        do_req(32'h44, 4'd7, 32'hDEADBEEF);  check("sw_data", last_we_data, 32'hDEADBEEF);
        do_req(32'h44, 4'd2, 32'h0);         check("lw_after_sw", last_rd, 32'hDEADBEEF);
        do_req(32'h42, 4'd2, 32'h0);
        do_req(32'h41, 4'd6, 32'h1234);
        do_req(32'h40, 4'hF, 32'h0);
        do_req(32'hFFFF_F040, 4'd2, 32'h0);  check("alias_lw", last_rd, 32'h1299AABB);

        // Reset while an SH sits in DATA: nothing may be written
        @(negedge clk);
        we0 = we_cnt;
        req_valid = 1'b1; req_addr = 32'h42; req_access = 4'd6; req_wdata = 32'h5555;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        check("sh_in_data_stall", {31'd0, stall}, 32'd1);
        @(negedge clk); rstn = 1'b0;
        @(posedge clk); #1;
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        check("abort_stall", {31'd0, stall}, 32'd0);
        check("abort_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk); rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_write", 32'(we_cnt - we0), 32'd0);
        check("abort_mem", mem[16], ref_mem[16]);

        // Randomized traffic over a small aliased window
        for (int n = 0; n < 60; n++) begin
            a = $urandom;
            a[ADDR_W+1:2] = ADDR_W'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            acc = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            do_req(a, acc, $urandom);
        end
        for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);
        check("re_we_overlap", 32'(both_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop if the sequence ever wedges
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Sequences every data-memory access from the CPU MEM stage around the existing load/store alignment unit.
- For loads: issues a word read, passes the raw word to the alignment unit and returns the extended result.
- For SB/SH: performs the read-modify-write, reading the word, merging through the alignment unit and writing it back.
- For SW: writes directly. Drives a stall to the pipeline while busy.

Parameters:
ADDR_W, 10, word-address width of the data memory (depth 2^ADDR_W words)

Ports:
clk  in  1  clock, rising edge
rstn  in  1  reset, synchronous, active-low
req_valid  in  1  access request from MEM stage
req_ready  out  1  controller idle, can accept a request
req_addr  in  32  byte address
req_access  in  4  access code (LB=0, LH=1, LW=2, LBU=3, LHU=4, SB=5, SH=6, SW=7)
req_wdata  in  32  store data (rs2)
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load result; 0 for stores and errors
resp_err  out  1  misaligned or illegal access, valid with resp_valid
stall  out  1  high whenever state != IDLE
mem_addr  out  ADDR_W  word address = latched req_addr[ADDR_W+1:2]
mem_re  out  1  read strobe; mem_rdata valid the cycle after
mem_rdata  in  32  memory read word
mem_we  out  1  write strobe
mem_wdata  out  32  full word to write
slu_addr  out  32  latched byte address to alignment unit
slu_access  out  4  latched access code to alignment unit
slu_rd_in  out  32  raw memory word to alignment unit
slu_wd_in  out  32  latched store data to alignment unit
slu_rd_out  in  32  extended load value from alignment unit
slu_wd_out  in  32  merged store word from alignment unit

Behaviour:
- Reset (rstn=0 at an edge): state IDLE. All outputs 0 except req_ready=1. Any in-flight access is abandoned; no mem_we is issued on or after the reset edge.
- Accept: request taken on an edge with req_valid & req_ready. addr, access and wdata are latched; later changes on req_* are ignored.
- Error check at accept:
  - LH/LHU/SH with addr[0]=1 → error.
  - LW/SW with addr[1:0]!=0 → error.
  - Access code > 7 → error.
  - On error: go to RESP with no memory activity; resp_err=1, resp_rdata=0.
- States: IDLE, RD, DATA, WR, RESP.
- IDLE: req_ready=1. On accept go to RESP (error), WR (SW, mem_wdata=req_wdata), or RD (all others).
- RD: mem_re=1 for exactly one cycle → DATA.
- DATA:
  - slu_rd_in = mem_rdata.
  - Load: resp_rdata <= slu_rd_out, then → RESP.
  - SB/SH: mem_wdata <= slu_wd_out, then → WR.
- WR: mem_we=1 for exactly one cycle, mem_addr stable → RESP.
- RESP: resp_valid=1 for one cycle → IDLE. req_ready is low in RESP, so back-to-back requests have at least a 1-cycle gap after the response.
- Latency, acceptance edge to resp_valid high:
  - Error: 1 cycle.
  - SW: 2 cycles.
  - Loads: 3 cycles.
  - SB/SH: 4 cycles.
- Address wrap: bits above ADDR_W+1 are ignored, so the address aliases modulo 2^ADDR_W words.
- mem_re and mem_we are never high in the same cycle.
- resp_rdata and resp_err hold their value until the next response.

Decomposition:
- Shared package holds:
  - the access-code constants (LB..SW), shared with the alignment unit;
  - the state enum;
  - a function is_store(access).
- One sub-module, dmem_align_chk: combinational (addr[1:0], access) → err.

Test Plan:
- mem[0x40>>2]=0x8899AABB; LB addr=0x41 → resp_valid 3 cycles after accept, resp_rdata=0xFFFFFFAA, err=0.
- Same word; LHU addr=0x42 → resp_rdata=0x00008899. LW addr=0x40 → 0x8899AABB.
- SB addr=0x43 wdata=0x12 → exactly one mem_we pulse with mem_wdata=0x1299AABB; resp 4 cycles after accept. Subsequent LW returns 0x1299AABB.
- SW addr=0x44 wdata=0xDEADBEEF → no mem_re, mem_we on the cycle after accept, resp 2 cycles after accept.
- LW addr=0x42, SH addr=0x41, access=4'hF → resp_err=1 after 1 cycle, no mem_re/mem_we, resp_rdata=0.
- Assert rstn=0 while in DATA of an SH → next cycle IDLE, req_ready=1, stall=0. No mem_we ever seen; memory unchanged.
